mccu_fsm: RTL and testbench
===========================

Name: mccu_fsm

Overview:
- Multi-cycle MIPS control unit: a 5-state FSM that sequences a shared-ALU, single-memory datapath through IF/ID/EXE/MEM/WB.
- Decodes the same 22-instruction subset as the single-cycle control unit: add sub and or xor nor slt sll srl sra jr addi andi ori xori lw sw beq bne lui j jal.
- Handshakes with unified instruction/data memory via mem_ready.
- Sits between instruction register/ALU flags and the multi-cycle datapath muxes and write enables.

Parameters:
- none (state encoding is fixed below)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]; valid from ID onward
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag (current-cycle ALU result)
- mem_ready  in  1  memory completes the current access this cycle
- state  out  3  0=IF 1=ID 2=EXE 3=MEM 4=WB
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- wmem  out  1  memory write enable
- wreg  out  1  register file write enable
- iord  out  1  memory address select: 0=PC, 1=ALU-out register
- alusrca  out  1  ALU A select: 0=PC, 1=rs (or sa when shift=1)
- alusrcb  out  2  ALU B select: 00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- aluc  out  4  ALU op
- shift  out  1  A operand takes sa
- sext  out  1  immediate sign-extend (else zero-extend)
- regrt  out  1  destination = rt (else rd)
- m2reg  out  1  write-back data from memory data register
- jal  out  1  destination = $31, data = PC
- pcsource  out  2  00=ALU, 01=branch target (ALU-out reg), 10=rs, 11=jump addr

Behaviour:
- state is registered; all other outputs are combinational from state, op, func, z, mem_ready.
- Unlisted outputs are 0 in every state.
- rst=1 at an edge: state<=IF. While rst=1: wpc, wir, wmem, wreg forced 0, including reset asserted mid-MEM or mid-WB. Counts as a full abort; no partial write.
- aluc encoding: add/addi/lw/sw/PC arithmetic 0000; sub 0100; and/andi 0001; or/ori 0101; xor/xori 0010; beq/bne 0010; lui 0110; sll 0011; srl 0111; sra 1111; slt 1000; nor 1101.
- sext = addi|lw|sw|beq|bne; shift = sll|srl|sra.
- IF:
  - iord=0, alusrca=0, alusrcb=01, aluc=0000, pcsource=00.
  - wir=wpc=mem_ready.
  - mem_ready=0: stay in IF, no writes. mem_ready=1: go to ID.
- ID:
  - j: pcsource=11, wpc=1, go to IF.
  - jal: pcsource=11, wpc=1, wreg=1, jal=1 (writes PC+4 to $31), go to IF.
  - jr: pcsource=10, wpc=1, go to IF.
  - Any other legal instruction: alusrca=0, alusrcb=11, sext=1, aluc=0000 (branch target precomputed into ALU-out register), go to EXE.
  - Illegal op/func: no writes, go to IF; executes as a nop, PC already advanced.
- EXE:
  - beq/bne: alusrca=1, alusrcb=00, aluc=0010, pcsource=01. wpc = beq&z | bne&~z. Go to IF.
  - lw/sw: alusrca=1, alusrcb=10, aluc=0000, go to MEM.
  - R-type ALU: alusrca=1, alusrcb=00, go to WB.
  - addi/andi/ori/xori/lui: alusrca=1, alusrcb=10, go to WB.
- MEM:
  - iord=1.
  - lw: wait for mem_ready=1, then go to WB.
  - sw: wmem=1 held every cycle until mem_ready=1, then go to IF.
  - Address must stay stable while waiting; the ALU-out register is not rewritten in MEM.
- WB:
  - wreg=1. regrt=1 for immediates and lw. m2reg=lw.
  - Go to IF.
- Latency in cycles with zero memory wait: j/jal/jr 2; beq/bne 3; R/immediate 4; sw 4; lw 5. Each mem_ready=0 cycle in IF or MEM adds 1.
- Unused encodings 5..7 (state register corruption only) go to IF with no writes.

Test Plan:
- rst=1 for 2 cycles, then add $3,$1,$2 with mem_ready=1 → state 0,1,2,4,0. wreg=1 only in WB with regrt=0, aluc=0000; wir/wpc pulse only in IF.
- lw with mem_ready low 2 cycles in IF and 3 in MEM → 10 cycles total. iord=1 throughout MEM; wreg=1,m2reg=1 in WB; no early wir.
- beq with z=1 → wpc=1, pcsource=01 in EXE. Same with z=0 → wpc=0. bne gives the opposite; both return to IF after 3 cycles.
- jal → in ID: wpc=1, pcsource=11, wreg=1, jal=1; next state IF. jr → pcsource=10, no wreg.
- sw with mem_ready=0 for 3 cycles in MEM → wmem=1 for 4 cycles. Assert rst on the 2nd MEM cycle → wmem=0 that cycle, state=IF next.
- op=6'b111111 → ID asserts no write enable; returns to IF after 2 cycles. sra → aluc=1111, shift=1 in EXE.

Source files
------------

// File: rtl/mccu_fsm_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master side (the controller) reads IR fields, ALU zero and memory ready, and drives mux selects and write enables.
interface mccu_fsm_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       z;
   logic       mem_ready;

   logic [2:0] state;
   logic       wpc;
   logic       wir;
   logic       wmem;
   logic       wreg;
   logic       iord;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [3:0] aluc;
   logic       shift;
   logic       sext;
   logic       regrt;
   logic       m2reg;
   logic       jal;
   logic [1:0] pcsource;

   modport master (
      input  op, func, z, mem_ready,
      output state, wpc, wir, wmem, wreg, iord, alusrca, alusrcb, aluc,
             shift, sext, regrt, m2reg, jal, pcsource
   );

   modport slave (
      output op, func, z, mem_ready,
      input  state, wpc, wir, wmem, wreg, iord, alusrca, alusrcb, aluc,
             shift, sext, regrt, m2reg, jal, pcsource
   );
endinterface

// File: rtl/mccu_fsm.sv
// Multi-cycle MIPS control unit: a five-state IF/ID/EXE/MEM/WB sequencer for a shared-ALU, single-memory datapath.
// Only the state is registered; every other output is decoded combinationally from state, IR fields, ALU zero and mem_ready.
module mccu_fsm (
   input  logic       clk_i,
   input  logic       rst_i,
   mccu_fsm_if.master bus
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;

   state_e state_q, state_d;

   logic r_type;
   logic i_add, i_sub, i_and, i_or, i_xor, i_nor, i_slt, i_sll, i_srl, i_sra, i_jr;
   logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
   logic is_r_alu, is_imm, is_legal;
   logic sext_dec, shift_dec;
   logic [3:0] aluc_dec;

   logic       wpc_c, wir_c, wmem_c, wreg_c;
   logic       iord_c, alusrca_c, shift_c, sext_c, regrt_c, m2reg_c, jal_c;
   logic [1:0] alusrcb_c, pcsource_c;
   logic [3:0] aluc_c;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      r_type = (bus.op == OP_RTYPE);
      i_add  = r_type && (bus.func == FN_ADD);
      i_sub  = r_type && (bus.func == FN_SUB);
      i_and  = r_type && (bus.func == FN_AND);
      i_or   = r_type && (bus.func == FN_OR);
      i_xor  = r_type && (bus.func == FN_XOR);
      i_nor  = r_type && (bus.func == FN_NOR);
      i_slt  = r_type && (bus.func == FN_SLT);
      i_sll  = r_type && (bus.func == FN_SLL);
      i_srl  = r_type && (bus.func == FN_SRL);
      i_sra  = r_type && (bus.func == FN_SRA);
      i_jr   = r_type && (bus.func == FN_JR);
      i_addi = (bus.op == OP_ADDI);
      i_andi = (bus.op == OP_ANDI);
      i_ori  = (bus.op == OP_ORI);
      i_xori = (bus.op == OP_XORI);
      i_lui  = (bus.op == OP_LUI);
      i_lw   = (bus.op == OP_LW);
      i_sw   = (bus.op == OP_SW);
      i_beq  = (bus.op == OP_BEQ);
      i_bne  = (bus.op == OP_BNE);
      i_j    = (bus.op == OP_J);
      i_jal  = (bus.op == OP_JAL);

      is_r_alu = i_add | i_sub | i_and | i_or | i_xor | i_nor | i_slt | i_sll | i_srl | i_sra;
      is_imm   = i_addi | i_andi | i_ori | i_xori | i_lui;
      is_legal = is_r_alu | i_jr | is_imm | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

      sext_dec  = i_addi | i_lw | i_sw | i_beq | i_bne;
      shift_dec = i_sll | i_srl | i_sra;

      // Branches compare by XOR so the zero flag means rs == rt.
      aluc_dec = 4'b0000;
      if (i_sub)                   aluc_dec = 4'b0100;
      else if (i_and | i_andi)     aluc_dec = 4'b0001;
      else if (i_or | i_ori)       aluc_dec = 4'b0101;
      else if (i_xor | i_xori)     aluc_dec = 4'b0010;
      else if (i_beq | i_bne)      aluc_dec = 4'b0010;
      else if (i_lui)              aluc_dec = 4'b0110;
      else if (i_sll)              aluc_dec = 4'b0011;
      else if (i_srl)              aluc_dec = 4'b0111;
      else if (i_sra)              aluc_dec = 4'b1111;
      else if (i_slt)              aluc_dec = 4'b1000;
      else if (i_nor)              aluc_dec = 4'b1101;
   end

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d    = S_IF;
      wpc_c      = 1'b0;
      wir_c      = 1'b0;
      wmem_c     = 1'b0;
      wreg_c     = 1'b0;
      iord_c     = 1'b0;
      alusrca_c  = 1'b0;
      alusrcb_c  = 2'b00;
      aluc_c     = 4'b0000;
      shift_c    = 1'b0;
      sext_c     = 1'b0;
      regrt_c    = 1'b0;
      m2reg_c    = 1'b0;
      jal_c      = 1'b0;
      pcsource_c = 2'b00;

      case (state_q)
         S_IF: begin
            alusrcb_c = 2'b01;
            wpc_c     = bus.mem_ready;
            wir_c     = bus.mem_ready;
            state_d   = bus.mem_ready ? S_ID : S_IF;
         end
         S_ID: begin
            if (i_j | i_jal) begin
               pcsource_c = 2'b11;
               wpc_c      = 1'b1;
               wreg_c     = i_jal;
               jal_c      = i_jal;
            end else if (i_jr) begin
               pcsource_c = 2'b10;
               wpc_c      = 1'b1;
            end else if (is_legal) begin
               // Branch target is computed here while the ALU is otherwise idle.
               alusrcb_c = 2'b11;
               sext_c    = 1'b1;
               state_d   = S_EXE;
            end
         end
         S_EXE: begin
            aluc_c = aluc_dec;
            sext_c = sext_dec;
            if (i_beq | i_bne) begin
               alusrca_c  = 1'b1;
               pcsource_c = 2'b01;
               wpc_c      = (i_beq & bus.z) | (i_bne & ~bus.z);
            end else if (i_lw | i_sw) begin
               alusrca_c = 1'b1;
               alusrcb_c = 2'b10;
               state_d   = S_MEM;
            end else if (is_r_alu) begin
               alusrca_c = 1'b1;
               shift_c   = shift_dec;
               state_d   = S_WB;
            end else if (is_imm) begin
               alusrca_c = 1'b1;
               alusrcb_c = 2'b10;
               state_d   = S_WB;
            end
         end
         S_MEM: begin
            iord_c = 1'b1;
            if (i_lw) begin
               state_d = bus.mem_ready ? S_WB : S_MEM;
            end else if (i_sw) begin
               wmem_c  = 1'b1;
               state_d = bus.mem_ready ? S_IF : S_MEM;
            end
         end
         S_WB: begin
            wreg_c  = 1'b1;
            regrt_c = is_imm | i_lw;
            m2reg_c = i_lw;
         end
         default: state_d = S_IF;
      endcase
   end

   // Reset aborts the instruction in flight: no architectural write may slip through.
   assign bus.wpc      = wpc_c  & ~rst_i;
   assign bus.wir      = wir_c  & ~rst_i;
   assign bus.wmem     = wmem_c & ~rst_i;
   assign bus.wreg     = wreg_c & ~rst_i;
   assign bus.state    = state_q;
   assign bus.iord     = iord_c;
   assign bus.alusrca  = alusrca_c;
   assign bus.alusrcb  = alusrcb_c;
   assign bus.aluc     = aluc_c;
   assign bus.shift    = shift_c;
   assign bus.sext     = sext_c;
   assign bus.regrt    = regrt_c;
   assign bus.m2reg    = m2reg_c;
   assign bus.jal      = jal_c;
   assign bus.pcsource = pcsource_c;

endmodule

// File: tb/tb_mccu_fsm.sv
// Directed bench for mccu_fsm: each driven cycle queues its hand-derived control vector,
// and an independent monitor compares the DUT outputs mid-cycle.
module tb_mccu_fsm;

   typedef struct packed {
      logic [2:0] state;
      logic       wpc;
      logic       wir;
      logic       wmem;
      logic       wreg;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluc;
      logic       shift;
      logic       sext;
      logic       regrt;
      logic       m2reg;
      logic       jal;
      logic [1:0] pcsource;
   } exp_t;

   typedef struct {
      exp_t  e;
      string name;
   } sb_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_ILL  = 6'b111111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mccu_fsm_if bus ();

   mccu_fsm dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t e_if(input logic mr);
      exp_t e;
      e = '0;
      e.state   = 3'd0;
      e.alusrcb = 2'b01;
      e.wpc     = mr;
      e.wir     = mr;
      return e;
   endfunction

   function automatic exp_t e_id();
      exp_t e;
      e = '0;
      e.state   = 3'd1;
      e.alusrcb = 2'b11;
      e.sext    = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_id_jump(input logic [1:0] pcs, input logic link);
      exp_t e;
      e = '0;
      e.state    = 3'd1;
      e.wpc      = 1'b1;
      e.pcsource = pcs;
      e.wreg     = link;
      e.jal      = link;
      return e;
   endfunction

   function automatic exp_t e_id_nop();
      exp_t e;
      e = '0;
      e.state = 3'd1;
      return e;
   endfunction

   function automatic exp_t e_exe(input logic [1:0] srcb, input logic [3:0] aluc,
                                  input logic sh, input logic sx);
      exp_t e;
      e = '0;
      e.state   = 3'd2;
      e.alusrca = 1'b1;
      e.alusrcb = srcb;
      e.aluc    = aluc;
      e.shift   = sh;
      e.sext    = sx;
      return e;
   endfunction

   function automatic exp_t e_exe_br(input logic take);
      exp_t e;
      e = e_exe(2'b00, 4'b0010, 1'b0, 1'b1);
      e.pcsource = 2'b01;
      e.wpc      = take;
      return e;
   endfunction

   function automatic exp_t e_mem(input logic wm);
      exp_t e;
      e = '0;
      e.state = 3'd3;
      e.iord  = 1'b1;
      e.wmem  = wm;
      return e;
   endfunction

   function automatic exp_t e_wb(input logic rt, input logic m2r, input logic we);
      exp_t e;
      e = '0;
      e.state = 3'd4;
      e.wreg  = we;
      e.regrt = rt;
      e.m2reg = m2r;
      return e;
   endfunction

   // Drive one cycle of inputs, queue its expected outputs, and advance past the next edge.
   task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic r, input exp_t e);
      sb_t s;
      bus.op        = op;
      bus.func      = fn;
      bus.z         = z;
      bus.mem_ready = mr;
      rst           = r;
      s.e    = e;
      s.name = nm;
      sb_q.push_back(s);
      @(posedge clk);
      #1;
   endtask

   task automatic run_alu(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic [1:0] srcb, input logic [3:0] aluc,
                          input logic sh, input logic sx, input logic rt);
      cyc({nm, " IF"},  op, fn, 1'b0, 1'b1, 1'b0, e_if(1'b1));
      cyc({nm, " ID"},  op, fn, 1'b0, 1'b1, 1'b0, e_id());
      cyc({nm, " EXE"}, op, fn, 1'b0, 1'b1, 1'b0, e_exe(srcb, aluc, sh, sx));
      cyc({nm, " WB"},  op, fn, 1'b0, 1'b1, 1'b0, e_wb(rt, 1'b0, 1'b1));
   endtask

   task automatic run_br(input string nm, input logic [5:0] op, input logic z, input logic take);
      cyc({nm, " IF"},  op, 6'd0, z, 1'b1, 1'b0, e_if(1'b1));
      cyc({nm, " ID"},  op, 6'd0, z, 1'b1, 1'b0, e_id());
      cyc({nm, " EXE"}, op, 6'd0, z, 1'b1, 1'b0, e_exe_br(take));
   endtask

   task automatic run_jmp(input string nm, input logic [5:0] op, input logic [5:0] fn, input exp_t id_e);
      cyc({nm, " IF"}, op, fn, 1'b0, 1'b1, 1'b0, e_if(1'b1));
      cyc({nm, " ID"}, op, fn, 1'b0, 1'b1, 1'b0, id_e);
   endtask

   initial begin : monitor
      sb_t  s;
      exp_t a;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            a.state    = bus.state;
            a.wpc      = bus.wpc;
            a.wir      = bus.wir;
            a.wmem     = bus.wmem;
            a.wreg     = bus.wreg;
            a.iord     = bus.iord;
            a.alusrca  = bus.alusrca;
            a.alusrcb  = bus.alusrcb;
            a.aluc     = bus.aluc;
            a.shift    = bus.shift;
            a.sext     = bus.sext;
            a.regrt    = bus.regrt;
            a.m2reg    = bus.m2reg;
            a.jal      = bus.jal;
            a.pcsource = bus.pcsource;
            n_cmp++;
            if (a !== s.e) begin
               n_bad++;
               $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                        s.name, a.state, a, s.e.state, s.e);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus.op        = 6'd0;
      bus.func      = 6'd0;
      bus.z         = 1'b0;
      bus.mem_ready = 1'b1;
      rst           = 1'b1;
      @(posedge clk);
      #1;
      cyc("reset hold", OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, e_if(1'b0));

      run_alu("add", OP_R, FN_ADD, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

      cyc("lw IF wait0", OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, e_if(1'b0));
      cyc("lw IF wait1", OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, e_if(1'b0));
      cyc("lw IF",       OP_LW, 6'd0, 1'b0, 1'b1, 1'b0, e_if(1'b1));
      cyc("lw ID",       OP_LW, 6'd0, 1'b0, 1'b1, 1'b0, e_id());
      cyc("lw EXE",      OP_LW, 6'd0, 1'b0, 1'b1, 1'b0, e_exe(2'b10, 4'b0000, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++)
         cyc("lw MEM wait", OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, e_mem(1'b0));
      cyc("lw MEM",      OP_LW, 6'd0, 1'b0, 1'b1, 1'b0, e_mem(1'b0));
      cyc("lw WB",       OP_LW, 6'd0, 1'b0, 1'b1, 1'b0, e_wb(1'b1, 1'b1, 1'b1));

      run_br("beq z1", OP_BEQ, 1'b1, 1'b1);
      run_br("beq z0", OP_BEQ, 1'b0, 1'b0);
      run_br("bne z1", OP_BNE, 1'b1, 1'b0);
      run_br("bne z0", OP_BNE, 1'b0, 1'b1);

      run_jmp("jal", OP_JAL, 6'd0, e_id_jump(2'b11, 1'b1));
      run_jmp("jr",  OP_R,   FN_JR, e_id_jump(2'b10, 1'b0));
      run_jmp("j",   OP_J,   6'd0, e_id_jump(2'b11, 1'b0));

      cyc("sw IF",  OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, e_if(1'b1));
      cyc("sw ID",  OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, e_id());
      cyc("sw EXE", OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, e_exe(2'b10, 4'b0000, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++)
         cyc("sw MEM wait", OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, e_mem(1'b1));
      cyc("sw MEM done", OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, e_mem(1'b1));

      cyc("sw2 IF",   OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, e_if(1'b1));
      cyc("sw2 ID",   OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, e_id());
      cyc("sw2 EXE",  OP_SW, 6'd0, 1'b0, 1'b1, 1'b0, e_exe(2'b10, 4'b0000, 1'b0, 1'b1));
      cyc("sw2 MEM1", OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, e_mem(1'b1));
      cyc("sw2 MEM rst", OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_mem(1'b0));

      cyc("ill IF", OP_ILL, 6'd0, 1'b0, 1'b1, 1'b0, e_if(1'b1));
      cyc("ill ID", OP_ILL, 6'd0, 1'b0, 1'b1, 1'b0, e_id_nop());

      run_alu("sra",  OP_R,    FN_SRA, 2'b00, 4'b1111, 1'b1, 1'b0, 1'b0);
      run_alu("slt",  OP_R,    FN_SLT, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0);
      run_alu("nor",  OP_R,    FN_NOR, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0);
      run_alu("addi", OP_ADDI, 6'd0,   2'b10, 4'b0000, 1'b0, 1'b1, 1'b1);
      run_alu("andi", OP_ANDI, 6'd0,   2'b10, 4'b0001, 1'b0, 1'b0, 1'b1);
      run_alu("lui",  OP_LUI,  6'd0,   2'b10, 4'b0110, 1'b0, 1'b0, 1'b1);

      cyc("addwb IF",  OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, e_if(1'b1));
      cyc("addwb ID",  OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, e_id());
      cyc("addwb EXE", OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, e_exe(2'b00, 4'b0000, 1'b0, 1'b0));
      cyc("addwb WB rst", OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, e_wb(1'b0, 1'b0, 1'b0));
      cyc("post rst IF", OP_R, FN_ADD, 1'b0, 1'b0, 1'b0, e_if(1'b0));

      repeat (2) @(posedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
